// File: rtl/usb_spi_pkg.sv
// ============================================================================
//  Module   : usb_spi_pkg
//  Purpose  : Shared types and command-byte field positions for the USB-host
//             SPI responder.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package usb_spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  localparam int ADDR_W        = 5;
  localparam int CMD_ADDR_MSB  = 7;
  localparam int CMD_ADDR_LSB  = 3;
  localparam int CMD_DIR_BIT   = 1;

  localparam int DEF_NUM_REGS  = 32;
  localparam int DEF_IRQ_ADDR  = 25;
  localparam int DEF_IEN_ADDR  = 26;

endpackage

`default_nettype wire

// File: rtl/spi_sync_edge.sv
// ============================================================================
//  Module   : spi_sync_edge
//  Purpose  : Two-flop synchroniser for one asynchronous SPI pin, plus a
//             third flop that yields single-cycle rise/fall strobes.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic async_in,
  output logic sync_out,
  output logic rise_out,
  output logic fall_out
);

  logic [2:0] sync_q;
  logic [2:0] sync_d;

  always_comb sync_d = {sync_q[1:0], async_in};

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) sync_q <= {3{RST_VAL}};
    else        sync_q <= sync_d;
  end

  assign sync_out = sync_q[1];
  assign rise_out = sync_q[1] & ~sync_q[2];
  assign fall_out = ~sync_q[1] & sync_q[2];

endmodule

`default_nettype wire

// File: rtl/usb_spi_responder.sv
// ============================================================================
//  Module   : usb_spi_responder
//  Purpose  : SPI mode-0 peripheral emulating the USB host-controller register
//             port. Optional interrupt logic enabled by macro USB_SPI_IRQ_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module usb_spi_responder
  import usb_spi_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int IRQ_ADDR = DEF_IRQ_ADDR,
  parameter int IEN_ADDR = DEF_IEN_ADDR
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              sclk_in,
  input  logic              n_ss_in,
  input  logic              mosi_in,
  output logic              miso_out,
  output logic              n_int_out,
  input  logic [7:0]        irq_set_in,
  output logic              wr_valid_out,
  output logic [ADDR_W-1:0] wr_addr_out,
  output logic [7:0]        wr_data_out
);

  logic sclk_rise, sclk_fall, unused_sclk_lvl;
  logic ss_lvl, ss_rise, ss_fall;
  logic mosi_lvl, unused_mosi_rise, unused_mosi_fall;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk_in(clk_in), .rst_in(rst_in), .async_in(sclk_in),
    .sync_out(unused_sclk_lvl), .rise_out(sclk_rise), .fall_out(sclk_fall));
  spi_sync_edge #(.RST_VAL(1'b1)) u_sync_ss (
    .clk_in(clk_in), .rst_in(rst_in), .async_in(n_ss_in),
    .sync_out(ss_lvl), .rise_out(ss_rise), .fall_out(ss_fall));
  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk_in(clk_in), .rst_in(rst_in), .async_in(mosi_in),
    .sync_out(mosi_lvl), .rise_out(unused_mosi_rise), .fall_out(unused_mosi_fall));

  state_e             state_q, state_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [6:0]         shift_in_q, shift_in_d;
  logic [7:0]         shift_out_q, shift_out_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               dir_q, dir_d;
  logic               miso_q, miso_d;
  logic               n_int_q, n_int_d;
  logic               wr_valid_q, wr_valid_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [7:0]         wr_data_q, wr_data_d;
  logic [7:0]         regs_q [NUM_REGS];
  logic [7:0]         regs_d [NUM_REGS];

  logic               active, byte_done, wr_hit, rd_hit;
  logic [7:0]         byte_in, rd_data, irq_val, ien_val;
  logic [ADDR_W-1:0]  cmd_addr, rd_addr;

  assign active    = (state_q != ST_IDLE) && !ss_lvl;
  assign byte_done = active && sclk_rise && (bit_cnt_q == 3'd7);
  assign byte_in   = {shift_in_q, mosi_lvl};
  assign cmd_addr  = byte_in[CMD_ADDR_MSB:CMD_ADDR_LSB];
  // During CMD the read target is the address being received, not the stale one.
  assign rd_addr   = (state_q == ST_CMD) ? cmd_addr : addr_q;
  assign wr_hit    = byte_done && (state_q == ST_DATA) && dir_q && rd_hit;

  always_comb begin
    rd_data = '0;
    rd_hit  = 1'b0;
    irq_val = '0;
    ien_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr == ADDR_W'(i)) begin
        rd_data = regs_q[i];
        rd_hit  = 1'b1;
      end
      if (i == IRQ_ADDR) irq_val = regs_q[i];
      if (i == IEN_ADDR) ien_val = regs_q[i];
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (ss_fall)   state_d = ST_CMD;
      ST_CMD:  if (byte_done) state_d = ST_DATA;
      ST_DATA: state_d = ST_DATA;
      default: state_d = ST_IDLE;
    endcase
    if (ss_rise) state_d = ST_IDLE;
  end

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shift_in_d  = shift_in_q;
    shift_out_d = shift_out_q;
    addr_d      = addr_q;
    dir_d       = dir_q;
    miso_d      = miso_q;
    wr_valid_d  = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    if ((state_q == ST_IDLE) && ss_fall) begin
      // Status MSB goes out immediately so it is valid before the first SCLK rise.
      miso_d      = irq_val[7];
      shift_out_d = {irq_val[6:0], 1'b0};
      bit_cnt_d   = 3'd0;
    end else if (active) begin
      if (sclk_rise) begin
        shift_in_d = byte_in[6:0];
        bit_cnt_d  = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          if (state_q == ST_CMD) begin
            addr_d      = cmd_addr;
            dir_d       = byte_in[CMD_DIR_BIT];
            shift_out_d = byte_in[CMD_DIR_BIT] ? 8'h00 : rd_data;
          end else if (dir_q) begin
            wr_valid_d = wr_hit;
            if (wr_hit) begin
              wr_addr_d = addr_q;
              wr_data_d = byte_in;
            end
          end else begin
            shift_out_d = rd_data;
          end
        end
      end
      if (sclk_fall) begin
        miso_d      = shift_out_q[7];
        shift_out_d = {shift_out_q[6:0], 1'b0};
      end
    end
    if (ss_rise) bit_cnt_d = 3'd0;
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
`ifdef USB_SPI_IRQ_EN
      if (i == IRQ_ADDR) begin
        regs_d[i] = ((wr_hit && addr_q == ADDR_W'(i)) ? (regs_q[i] & ~byte_in) : regs_q[i])
                    | irq_set_in;
      end else if (wr_hit && addr_q == ADDR_W'(i)) begin
        regs_d[i] = byte_in;
      end
`else
      if (wr_hit && addr_q == ADDR_W'(i)) regs_d[i] = byte_in;
`endif
    end
  end

`ifdef USB_SPI_IRQ_EN
  assign n_int_d = ~|(irq_val & ien_val);
`else
  logic unused_cfg;
  assign unused_cfg = ^{irq_set_in, ien_val};
  assign n_int_d    = 1'b1;
`endif

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      bit_cnt_q   <= '0;
      shift_in_q  <= '0;
      shift_out_q <= '0;
      addr_q      <= '0;
      dir_q       <= 1'b0;
      miso_q      <= 1'b0;
      n_int_q     <= 1'b1;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      shift_in_q  <= shift_in_d;
      shift_out_q <= shift_out_d;
      addr_q      <= addr_d;
      dir_q       <= dir_d;
      miso_q      <= miso_d;
      n_int_q     <= n_int_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign miso_out     = miso_q;
  assign n_int_out    = n_int_q;
  assign wr_valid_out = wr_valid_q;
  assign wr_addr_out  = wr_addr_q;
  assign wr_data_out  = wr_data_q;

endmodule

`default_nettype wire

// File: tb/tb_usb_spi_responder.sv
// ============================================================================
//  Module   : tb_usb_spi_responder
//  Purpose  : Self-checking bench: SPI master tasks driving a 32-register and
//             a 16-register responder, compared against an array-based model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_usb_spi_responder;

`ifdef USB_SPI_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif
  localparam int IRQ_A = 25;
  localparam int IEN_A = 26;

  typedef logic [7:0] buf_t [8];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b0, mosi = 1'b0, n_ss0 = 1'b1, n_ss1 = 1'b1;
  logic [7:0] irq_set0 = 8'h00, irq_set1 = 8'h00;

  logic       miso0, nint0, wv0, miso1, nint1, wv1;
  logic [4:0] wa0, wa1;
  logic [7:0] wd0, wd1;

  always #5 clk = ~clk;

  usb_spi_responder u_dut (
    .clk_in(clk), .rst_in(rst), .sclk_in(sclk), .n_ss_in(n_ss0), .mosi_in(mosi),
    .miso_out(miso0), .n_int_out(nint0), .irq_set_in(irq_set0),
    .wr_valid_out(wv0), .wr_addr_out(wa0), .wr_data_out(wd0));

  usb_spi_responder #(.NUM_REGS(16)) u_dut16 (
    .clk_in(clk), .rst_in(rst), .sclk_in(sclk), .n_ss_in(n_ss1), .mosi_in(mosi),
    .miso_out(miso1), .n_int_out(nint1), .irq_set_in(irq_set1),
    .wr_valid_out(wv1), .wr_addr_out(wa1), .wr_data_out(wd1));

  int checks = 0;
  int errors = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Every cycle of wr_valid is logged; a stretched pulse shows up as an extra entry.
  logic [12:0] wq0[$], wq1[$];
  always @(negedge clk) begin
    if (wv0) wq0.push_back({wa0, wd0});
    if (wv1) wq1.push_back({wa1, wd1});
  end

  // Reference register files: target 0 has 32 regs, target 1 has 16.
  logic [7:0] m0 [32];
  logic [7:0] m1 [16];

  function automatic logic [7:0] m_get(input int t, input int a);
    if (t == 0) return m0[a];
    return (a < 16) ? m1[a] : 8'h00;
  endfunction

  function automatic void m_wr(input int t, input int a, input logic [7:0] d);
    logic [7:0] v;
    if (t == 1 && a >= 16) return;
    v = (IRQ_ON && a == IRQ_A) ? (m_get(t, a) & ~d) : d;
    if (t == 0) m0[a] = v;
    else        m1[a] = v;
  endfunction

  function automatic logic m_nint(input int t);
    if (!IRQ_ON) return 1'b1;
    return ~|(m_get(t, IRQ_A) & m_get(t, IEN_A));
  endfunction

  task automatic spi_xfer(input int t, input buf_t tx, input int nbits, output buf_t rx);
    logic [7:0] b;
    rx = '{default: 8'h00};
    @(negedge clk);
    if (t == 0) n_ss0 = 1'b0; else n_ss1 = 1'b0;
    #40;
    for (int k = 0; k < nbits; k++) begin
      b    = tx[k/8];
      mosi = b[7 - (k % 8)];
      #40 sclk = 1'b1;
      b = rx[k/8];
      b[7 - (k % 8)] = (t == 0) ? miso0 : miso1;
      rx[k/8] = b;
      #40 sclk = 1'b0;
    end
    #40;
    if (t == 0) n_ss0 = 1'b1; else n_ss1 = 1'b1;
    mosi = 1'b0;
    #100;
  endtask

  // One transaction: command + n payload bytes; nbits>0 truncates (abort).
  task automatic txn(input int t, input logic [4:0] a, input bit wr, input int n,
                     input buf_t data, input int nbits, input string tag);
    buf_t        tx, rx;
    logic [12:0] exp_q[$];
    logic [12:0] got;
    logic [7:0]  st;
    int          nb, full, got_n;
    st = m_get(t, IRQ_A);
    tx = '{default: 8'h00};
    tx[0] = {a, 1'b0, wr, 1'b0};
    for (int k = 0; k < n && k < 7; k++) tx[k+1] = data[k];
    nb   = (nbits > 0) ? nbits : 8 * (n + 1);
    full = nb / 8 - 1;
    spi_xfer(t, tx, nb, rx);
    check_value({tag, "/status"}, {24'h0, rx[0]}, {24'h0, st});
    for (int k = 0; k < full; k++) begin
      if (wr) begin
        if (t == 0 || a < 16) exp_q.push_back({a, data[k]});
        m_wr(t, int'(a), data[k]);
      end else begin
        check_value($sformatf("%s/rd%0d", tag, k), {24'h0, rx[k+1]}, {24'h0, m_get(t, int'(a))});
      end
    end
    got_n = (t == 0) ? wq0.size() : wq1.size();
    check_value({tag, "/wr_cnt"}, got_n, exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got_n; k++) begin
      got = (t == 0) ? wq0[k] : wq1[k];
      check_value($sformatf("%s/wr%0d", tag, k), {19'h0, got}, {19'h0, exp_q[k]});
    end
    wq0.delete();
    wq1.delete();
    repeat (3) @(negedge clk);
    check_value({tag, "/n_int"}, (t == 0) ? nint0 : nint1, m_nint(t));
  endtask

  task automatic irq_pulse(input int t, input logic [7:0] v);
    @(negedge clk);
    if (t == 0) irq_set0 = v; else irq_set1 = v;
    @(negedge clk);
    irq_set0 = 8'h00;
    irq_set1 = 8'h00;
    if (IRQ_ON && t == 0) m0[IRQ_A] = m0[IRQ_A] | v;
    repeat (4) @(negedge clk);
    check_value("irq/n_int", (t == 0) ? nint0 : nint1, m_nint(t));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    buf_t d;
    int   t, n, nbits;
    bit   wr;
    logic [4:0] a;

    for (int i = 0; i < 32; i++) m0[i] = 8'h00;
    for (int i = 0; i < 16; i++) m1[i] = 8'h00;
    d = '{default: 8'h00};

    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check_value("rst/n_int0", nint0, 1'b1);
    check_value("rst/miso0",  miso0, 1'b0);
    check_value("rst/wv0",    wv0,   1'b0);
    check_value("rst/n_int1", nint1, 1'b1);
    check_value("rst/miso1",  miso1, 1'b0);
    for (int i = 0; i < 32; i++) txn(0, 5'(i), 1'b0, 1, d, 0, $sformatf("rst_rd0_%0d", i));
    for (int i = 0; i < 32; i += 5) txn(1, 5'(i), 1'b0, 1, d, 0, $sformatf("rst_rd1_%0d", i));

    d[0] = 8'hA5;
    txn(0, 5'd7, 1'b1, 1, d, 0, "wr7");
    txn(0, 5'd7, 1'b0, 2, d, 0, "rd7");

    d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33;
    txn(0, 5'd1, 1'b1, 3, d, 0, "burst1");
    txn(0, 5'd1, 1'b0, 3, d, 0, "rd1");

    d[0] = 8'h5C;
    txn(0, 5'd2, 1'b1, 1, d, 8 + 5, "abort2");
    txn(0, 5'd2, 1'b0, 1, d, 0, "rd2");

    d[0] = 8'h04;
    txn(0, 5'(IEN_A), 1'b1, 1, d, 0, "ien");
    irq_pulse(0, 8'h04);
    txn(0, 5'd0, 1'b0, 1, d, 0, "status");
    txn(0, 5'(IRQ_A), 1'b1, 1, d, 0, "w1c");

    d[0] = 8'h5A;
    txn(1, 5'd20, 1'b1, 1, d, 0, "oor_wr");
    txn(1, 5'd20, 1'b0, 1, d, 0, "oor_rd");

    for (int r = 0; r < 60; r++) begin
      t  = int'($urandom_range(0, 1));
      a  = 5'($urandom_range(0, 31));
      wr = 1'($urandom_range(0, 1));
      n  = int'($urandom_range(1, 3));
      for (int k = 0; k < 8; k++) d[k] = 8'($urandom);
      nbits = 0;
      if ($urandom_range(0, 7) == 0) begin
        n     = 3;
        nbits = int'($urandom_range(9, 23));
        if (nbits == 16) nbits = 15;
      end
      txn(t, a, wr, n, d, nbits, $sformatf("rnd%0d", r));
      if ($urandom_range(0, 4) == 0) irq_pulse(0, 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
